// File: rtl/readstream_pacer.sv
// Paces words from the SDRAM read FIFO into the UART transmitter, one word per baud-tick slot,
// with a programmable inter-word gap, run length, loop mode and FIFO/TX back-pressure.
module readstream_pacer #(
    parameter int unsigned CNT_W  = 23,
    parameter int unsigned GAP_W  = 5,
    parameter int unsigned RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic             cfg_loop,
    input  logic             tick,
    input  logic             fifo_empty,
    input  logic             tx_busy,
    output logic             sys_rd,
    output logic             txd_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] word_cnt
);

    typedef enum logic [1:0] {StIdle, StGap, StWait} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             loop_q, loop_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sys_rd_q, sys_rd_d;

    logic [CNT_W-1:0] cnt_inc;
    logic [GAP_W-1:0] gap_inc;
    logic             slot_ok;
    state_e           run_state;

    assign cnt_inc   = word_cnt_q + CNT_W'(1);
    assign gap_inc   = gap_cnt_q + GAP_W'(1);
    // A tick is only usable when both ends of the path can take a word right now.
    assign slot_ok   = tick & ~fifo_empty & ~tx_busy;
    assign run_state = (gap_q != '0) ? StGap : StWait;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        gap_d      = gap_q;
        gap_cnt_d  = gap_cnt_q;
        loop_d     = loop_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sys_rd_d   = 1'b0;

        if (abort) begin
            state_d   = StIdle;
            busy_d    = 1'b0;
            gap_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (cfg_len == '0) begin
                            done_d = 1'b1;
                        end else begin
                            len_d      = cfg_len;
                            gap_d      = cfg_gap;
                            loop_d     = cfg_loop;
                            word_cnt_d = '0;
                            gap_cnt_d  = '0;
                            busy_d     = 1'b1;
                            state_d    = (cfg_gap != '0) ? StGap : StWait;
                        end
                    end
                end
                StGap: begin
                    if (tick) begin
                        if (gap_inc == gap_q) begin
                            gap_cnt_d = '0;
                            state_d   = StWait;
                        end else begin
                            gap_cnt_d = gap_inc;
                        end
                    end
                end
                StWait: begin
                    if (slot_ok) begin
                        sys_rd_d = 1'b1;
                        if (cnt_inc == len_q) begin
                            if (loop_q) begin
                                word_cnt_d = '0;
                                state_d    = run_state;
                            end else begin
                                word_cnt_d = cnt_inc;
                                done_d     = 1'b1;
                                busy_d     = 1'b0;
                                state_d    = StIdle;
                            end
                        end else begin
                            word_cnt_d = cnt_inc;
                            state_d    = run_state;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            len_q      <= '0;
            word_cnt_q <= '0;
            gap_q      <= '0;
            gap_cnt_q  <= '0;
            loop_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sys_rd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            gap_q      <= gap_d;
            gap_cnt_q  <= gap_cnt_d;
            loop_q     <= loop_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sys_rd_q   <= sys_rd_d;
        end
    end

    // Load strobe trails the read by the FIFO latency; abort does not flush it, the words are
    // already popped.
    if (RD_LAT == 0) begin : g_no_lat
        assign txd_en = sys_rd_q;
    end else begin : g_lat
        logic [RD_LAT-1:0] dly_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dly_q <= '0;
            end else begin
                dly_q[0] <= sys_rd_q;
                for (int i = 1; i < int'(RD_LAT); i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
            end
        end

        assign txd_en = dly_q[RD_LAT-1];
    end

    assign sys_rd   = sys_rd_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign word_cnt = word_cnt_q;

endmodule
